// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster timing: pixel-rate divider, h/v counters and
// registered sync/bright decodes, plus a one-clock strobe at each frame start.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_SYNC_END  = 96,
    parameter int V_SYNC_END  = 2,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       frame_tick
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic             pix_en_q, pix_en_d;
    logic             bright_q, bright_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_tick_q, frame_tick_d;
    logic             div_last;

    always_comb begin
        div_last = (div_q == DIV_LAST);
        div_d    = div_last ? '0 : div_q + 1'b1;
        h_d      = h_q;
        v_d      = v_q;
        if (div_last) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        pix_en_d     = div_last;
        frame_tick_d = div_last && (h_q == H_LAST) && (v_q == V_LAST);
        // Decodes use the next counts so they line up with hCount/vCount.
        hsync_d  = !(h_d < 10'(H_SYNC_END));
        vsync_d  = !(v_d < 10'(V_SYNC_END));
        bright_d = (h_d >= 10'(H_VIS_START)) && (h_d < 10'(H_VIS_END)) &&
                   (v_d >= 10'(V_VIS_START)) && (v_d < 10'(V_VIS_END));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            h_q          <= '0;
            v_q          <= '0;
            pix_en_q     <= 1'b0;
            bright_q     <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            h_q          <= h_d;
            v_q          <= v_d;
            pix_en_q     <= pix_en_d;
            bright_q     <= bright_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pix_en     = pix_en_q;
    assign hCount     = h_q;
    assign vCount     = v_q;
    assign bright     = bright_q;
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset/line-wrap/hsync, and a small
// geometry instance so whole frames (tick spacing, window edges) fit the run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    logic       pe_a, br_a, hs_a, vs_a, ft_a;
    logic [9:0] h_a, v_a;
    logic       pe_b, br_b, hs_b, vs_b, ft_b;
    logic [9:0] h_b, v_b;

    vga_timing_gen dut (
        .clk(clk), .rst(rst_a), .pix_en(pe_a), .hCount(h_a), .vCount(v_a),
        .bright(br_a), .hSync(hs_a), .vSync(vs_a), .frame_tick(ft_a)
    );

    // Small frame: 40x20 pixels, 4 clks/pixel -> 3200 clks per frame.
    vga_timing_gen #(
        .CLK_DIV(4), .H_TOTAL(40), .V_TOTAL(20), .H_SYNC_END(4), .V_SYNC_END(2),
        .H_VIS_START(8), .H_VIS_END(36), .V_VIS_START(3), .V_VIS_END(18)
    ) dut_s (
        .clk(clk), .rst(rst_b), .pix_en(pe_b), .hCount(h_b), .vCount(v_b),
        .bright(br_b), .hSync(hs_b), .vSync(vs_b), .frame_tick(ft_b)
    );

    logic [24:0] obs_a, obs_b;
    assign obs_a = {pe_a, h_a, v_a, br_a, hs_a, vs_a, ft_a};
    assign obs_b = {pe_b, h_b, v_b, br_b, hs_b, vs_b, ft_b};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After release: 3 quiet edges, then pix_en with hCount=1 on the 4th.
    task automatic restart_seq(input bit sel, input string tag);
        @(negedge clk);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check({tag, "_quiet"}, 32'(sel ? obs_b : obs_a), 32'd0);
        end
        step();
        check({tag, "_first_pix"}, 32'(sel ? obs_b : obs_a), 32'({1'b1, 10'd1, 10'd0, 4'b0}));
        $display("%s: restart sequence checked", tag);
    endtask

    // pix_en spacing on the full-size instance, checked continuously.
    int  gap_a = 0;
    bit  seen_a = 0;
    always @(negedge clk) begin
        if (rst_a !== 1'b1) begin
            seen_a = 0;
            gap_a  = 0;
        end else if (pe_a) begin
            if (seen_a) check("pix_gap", 32'(gap_a), 32'd4);
            seen_a = 1;
            gap_a  = 1;
        end else begin
            gap_a++;
        end
    end

    initial begin
        int n, cnt_hs, tick_n, cyc, frames, run_hi;
        int hs_lo, vs_lo, br_hi, br_edge;
        int tick_at[3];
        bit found;

        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset held for 3 clocks
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outs", 32'(obs_a), 32'd0);
        end
        restart_seq(1'b0, "reset_a");

        // Line wrap at (799,10)
        found = 0;
        for (int i = 0; i < 40000 && !found; i++) begin
            step();
            if (pe_a && h_a == 10'd799 && v_a == 10'd10) found = 1;
        end
        check("reach_799_10", 32'(found), 32'd1);
        n = 0;
        do begin step(); n++; end while (!pe_a && n < 8);
        check("wrap_gap", 32'(n), 32'd4);
        check("wrap_h", 32'(h_a), 32'd0);
        check("wrap_v", 32'(v_a), 32'd11);
        $display("line wrap: h=%0d v=%0d", h_a, v_a);

        // One full line 11: hSync low slots and edge values
        cnt_hs = 0;
        n = 0;
        for (int i = 0; i < 3300 && n < 800; i++) begin
            if (pe_a) begin
                n++;
                if (!hs_a) cnt_hs++;
                if (h_a == 10'd95)  check("hsync_at_95", 32'(hs_a), 32'd0);
                if (h_a == 10'd96)  check("hsync_at_96", 32'(hs_a), 32'd1);
                if (h_a == 10'd799) check("hsync_at_799", 32'(hs_a), 32'd1);
                if (h_a == 10'd200) check("vsync_line11", 32'(vs_a), 32'd1);
            end
            step();
        end
        check("line_slots", 32'(n), 32'd800);
        check("hsync_low_count", 32'(cnt_hs), 32'd96);
        $display("line 11: hsync low for %0d pixels", cnt_hs);

        // Async reset between edges at hCount=400
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            step();
            if (pe_a && h_a == 10'd400) found = 1;
        end
        check("reach_h400", 32'(found), 32'd1);
        #2;
        rst_a = 1'b0;
        #1;
        check("async_rst_a_now", 32'(obs_a), 32'd0);
        step();
        check("async_rst_a_hold", 32'(obs_a), 32'd0);
        restart_seq(1'b0, "async_a");

        // Small instance: frame ticks over 3 frames, decode counts over one frame
        restart_seq(1'b1, "reset_b");
        cyc = 4;
        frames = 0;
        run_hi = 0;
        hs_lo = 0; vs_lo = 0; br_hi = 0; br_edge = 0;
        for (int i = 0; i < 9700; i++) begin
            step();
            cyc++;
            if (ft_b) begin
                run_hi++;
                if (frames < 3) tick_at[frames] = cyc;
                frames++;
                check("tick_h", 32'(h_b), 32'd0);
                check("tick_v", 32'(v_b), 32'd0);
                check("tick_pix", 32'(pe_b), 32'd1);
                $display("frame_tick %0d at clk %0d", frames, cyc);
            end else begin
                if (run_hi != 0) check("tick_width", 32'(run_hi), 32'd1);
                run_hi = 0;
            end
            if (pe_b && frames == 1) begin
                if (!hs_b) hs_lo++;
                if (!vs_b) vs_lo++;
                if (br_b)  br_hi++;
                if ((v_b == 10'd2 || v_b == 10'd18) && br_b) br_edge++;
                if (v_b == 10'd3) begin
                    if (h_b == 10'd7)  check("bright_h7",  32'(br_b), 32'd0);
                    if (h_b == 10'd8)  check("bright_h8",  32'(br_b), 32'd1);
                    if (h_b == 10'd35) check("bright_h35", 32'(br_b), 32'd1);
                    if (h_b == 10'd36) check("bright_h36", 32'(br_b), 32'd0);
                end
            end
        end
        check("tick_count", 32'(frames), 32'd3);
        check("tick_first", 32'(tick_at[0]), 32'd3200);
        check("tick_period1", 32'(tick_at[1] - tick_at[0]), 32'd3200);
        check("tick_period2", 32'(tick_at[2] - tick_at[1]), 32'd3200);
        check("frame_hsync_low", 32'(hs_lo), 32'd80);
        check("frame_vsync_low", 32'(vs_lo), 32'd80);
        check("frame_bright", 32'(br_hi), 32'd420);
        check("bright_outside_rows", 32'(br_edge), 32'd0);
        $display("small frame: hs_lo=%0d vs_lo=%0d bright=%0d", hs_lo, vs_lo, br_hi);

        // Async reset on small instance at (20,10)
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            step();
            if (pe_b && h_b == 10'd20 && v_b == 10'd10) found = 1;
        end
        check("reach_20_10", 32'(found), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        check("async_rst_b_now", 32'(obs_b), 32'd0);
        step();
        check("async_rst_b_hold", 32'(obs_b), 32'd0);
        restart_seq(1'b1, "async_b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
